// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the iterative multiply/divide unit
package muldiv_pkg;

    localparam int XLEN = 64;
    localparam int ITER = 64;

    // Operation code, identical to the RV64M funct3 field
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - radix-2 shift-add multiplier / restoring divider with fixed latency
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  op_e             op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e              state_q, state_d;
    logic [5:0]          cnt_q;
    op_e                 op_q;
    logic [XLEN-1:0]     a_q;
    logic                b_zero_q;
    logic                sa_q, sb_q;
    logic [XLEN-1:0]     opnd_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     result_q;

    logic                accept;
    logic                signed_a, signed_b, sa_in, sb_in;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum, div_part, div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   acc_step;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s, rem_s, fix_val;

    assign accept = (state_q == S_IDLE) && start;

    // Operand sign capture and magnitude conversion at latch time
    always_comb begin
        signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        sa_in    = signed_a & a[XLEN-1];
        sb_in    = signed_b & b[XLEN-1];
        a_mag    = sa_in ? -a : a;
        b_mag    = sb_in ? -b : b;
    end

    // One iteration: multiply adds the multiplicand into the upper half then shifts right;
    // divide shifts {rem,quo} left and subtracts the divisor when it fits
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_part = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_part - {1'b0, opnd_q};
        div_ge   = (div_part >= {1'b0, opnd_q});
        if (op_q[2]) begin
            acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_part[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction and output selection, including the divide-by-zero overrides
    always_comb begin
        prod_s = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_s  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:           fix_val = prod_s[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:         fix_val = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:  fix_val = b_zero_q ? '1 : quo_s;
            default:          fix_val = b_zero_q ? a_q : rem_s;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: 64 CALC cycles, then one FIX and one DONE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_CALC;
            S_CALC: if (cnt_q == 6'(ITER - 1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch, iteration counter, accumulator and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_zero_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            op_q     <= op;
            a_q      <= a;
            b_zero_q <= (b == '0);
            sa_q     <= sa_in;
            sb_q     <= sb_in;
            opnd_q   <= op[2] ? b_mag : a_mag;
            acc_q    <= {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
        end else if (state_q == S_CALC) begin
            cnt_q    <= cnt_q + 6'd1;
            acc_q    <= acc_step;
        end else if (state_q == S_FIX) begin
            result_q <= fix_val;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    op_e         op_s = OP_MUL;
    logic [63:0] a_s = '0;
    logic [63:0] b_s = '0;
    logic        busy, done;
    logic [63:0] result;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int          m_rem = 0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_res = '0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op_s),
        .a      (a_s),
        .b      (b_s),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [127:0] xs, xu, ys, yu, p;
        logic [63:0]  r;
        xs = {{64{x[63]}}, x};
        xu = {64'd0, x};
        ys = {{64{y[63]}}, y};
        yu = {64'd0, y};
        r  = '0;
        case (o)
            3'b000: begin p = xu * yu; r = p[63:0];   end
            3'b001: begin p = xs * ys; r = p[127:64]; end
            3'b010: begin p = xs * yu; r = p[127:64]; end
            3'b011: begin p = xu * yu; r = p[127:64]; end
            3'b100: begin
                if (y == 64'd0)                    r = ONES;
                else if (x == MINV && y == ONES)   r = x;
                else                               r = $signed(x) / $signed(y);
            end
            3'b101: r = (y == 64'd0) ? ONES : x / y;
            3'b110: begin
                if (y == 64'd0)                    r = x;
                else if (x == MINV && y == ONES)   r = 64'd0;
                else                               r = $signed(x) % $signed(y);
            end
            default: r = (y == 64'd0) ? x : x % y;
        endcase
        return r;
    endfunction

    // Cycle-level expectation: 66 busy cycles after an accepted start, done in the last,
    // result taking the model value when DONE is entered
    always @(posedge clk) begin
        if (reset) begin
            m_rem <= 0;
            m_res <= '0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_rem  <= 66;
                m_pend <= model(op_s, a_s, b_s);
            end
        end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) m_res <= m_pend;
        end
    end

    // Every-cycle comparison against the expectation
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {63'd0, busy}, {63'd0, (m_rem != 0)});
            chk("done", {63'd0, done}, {63'd0, (m_rem == 1)});
            chk("result", result, m_res);
        end
    end

    task automatic wait_done(input string nm, input logic [63:0] lit, input bit use_lit);
        int lat;
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        a_s   = ~a_s;
        b_s   = b_s ^ 64'h5A5A;
        op_s  = op_e'(3'(op_s + 3'd3));
        while (!done && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, " latency"}, 64'(lat), 64'd66);
        if (use_lit) chk({nm, " result"}, result, lit);
        @(negedge clk);
    endtask

    task automatic run_op(input op_e o, input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] lit, input bit use_lit, input string nm);
        if (use_lit) chk({nm, " model"}, model(o, x, y), lit);
        op_s  = o;
        a_s   = x;
        b_s   = y;
        start = 1'b1;
        @(posedge clk);
        wait_done(nm, lit, use_lit);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset result", result, 64'd0);
        reset = 1'b0;

        run_op(OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1, "mul 7*-3");
        run_op(OP_MULHU,  ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 1, "mulhu");
        run_op(OP_MULH,   ONES, ONES, 64'd0, 1, "mulh");
        run_op(OP_MULHSU, ONES, 64'd2, ONES, 1, "mulhsu");
        run_op(OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1, "div -7/2");
        run_op(OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 1, "rem -7/2");
        run_op(OP_DIVU,   64'd100, 64'd7, 64'd14, 1, "divu 100/7");
        run_op(OP_REMU,   64'd100, 64'd7, 64'd2, 1, "remu 100/7");
        run_op(OP_DIVU,   64'd5, 64'd0, ONES, 1, "divu by0");
        run_op(OP_DIV,    64'd5, 64'd0, ONES, 1, "div by0");
        run_op(OP_REM,    64'd5, 64'd0, 64'd5, 1, "rem by0");
        run_op(OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1, "rem neg by0");
        run_op(OP_DIV,    MINV, ONES, MINV, 1, "div ovf");
        run_op(OP_REM,    MINV, ONES, 64'd0, 1, "rem ovf");

        // start re-pulsed mid-CALC must be ignored
        op_s  = OP_MUL;
        a_s   = 64'd7;
        b_s   = 64'hFFFF_FFFF_FFFF_FFFD;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        op_s  = OP_DIVU;
        a_s   = 64'd1;
        b_s   = 64'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int lat;
            lat = 11;
            while (!done && lat < 200) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            chk("repulse latency", 64'(lat), 64'd66);
            chk("repulse result", result, 64'hFFFF_FFFF_FFFF_FFEB);
        end
        @(negedge clk);
        chk("repulse idle", {63'd0, busy}, 64'd0);

        // reset in the middle of CALC
        op_s  = OP_MULHU;
        a_s   = ONES;
        b_s   = ONES;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        chk("pre-reset busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset busy", {63'd0, busy}, 64'd0);
        chk("midreset done", {63'd0, done}, 64'd0);
        chk("midreset result", result, 64'd0);
        reset = 1'b0;
        run_op(OP_DIVU, 64'd100, 64'd7, 64'd14, 1, "after reset");

        // reset and start on the same edge: reset wins
        reset = 1'b1;
        start = 1'b1;
        op_s  = OP_MUL;
        a_s   = 64'd3;
        b_s   = 64'd3;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("reset+start busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("reset+start stay idle", {63'd0, busy}, 64'd0);

        // mixed operands, checked cycle by cycle against the model
        for (int i = 0; i < 8; i++) begin
            logic [63:0] x, y;
            x = {$urandom, $urandom};
            y = (i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
            run_op(op_e'(3'(i)), x, y, 64'd0, 0, "mix");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
